// File: rtl/me_pkg.sv
// Shared constants and FSM state type for the integer motion-estimation datapath.
package me_pkg;

  localparam int unsigned DEF_PIXEL    = 8;
  localparam int unsigned DEF_NUM_PE   = 8;
  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_NUM_CAND = 64;
  localparam int unsigned DEF_SAD_W    = DEF_PIXEL + $clog2(DEF_NUM_PE * DEF_ROWS);
  localparam int unsigned DEF_IDX_W    = $clog2(DEF_NUM_CAND);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } state_t;

endpackage

// File: rtl/sad_row_adder.sv
// Registered NUM_PE-input row adder with valid and sideband tag passthrough.
module sad_row_adder #(
  parameter int unsigned PIXEL  = 8,
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned TAG_W  = 1,
  parameter int unsigned SUM_W  = PIXEL + $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic [NUM_PE*PIXEL-1:0] i_row,
  input  logic [TAG_W-1:0]        i_tag,
  output logic                    o_valid,
  output logic [SUM_W-1:0]        o_sum,
  output logic [TAG_W-1:0]        o_tag
);

  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      w_sum = w_sum + SUM_W'(i_row[i*PIXEL +: PIXEL]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_tag   <= '0;
    end else begin
      o_valid <= i_valid & ~i_clr;
      if (i_valid) begin
        o_sum <= w_sum;
        o_tag <= i_tag;
      end
    end
  end

endmodule

// File: rtl/sad_min_select.sv
// Row-sum accumulation into candidate SADs with running minimum and index tracking.
module sad_min_select
  import me_pkg::*;
#(
  parameter int unsigned PIXEL    = DEF_PIXEL,
  parameter int unsigned NUM_PE   = DEF_NUM_PE,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned NUM_CAND = DEF_NUM_CAND,
  parameter int unsigned SAD_W    = PIXEL + $clog2(NUM_PE * ROWS),
  parameter int unsigned IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    search_start,
  input  logic                    abs_valid,
  input  logic [NUM_PE*PIXEL-1:0] abs_row,
  output logic                    busy,
  output logic [SAD_W-1:0]        cand_sad,
  output logic                    cand_valid,
  output logic [SAD_W-1:0]        best_sad,
  output logic [IDX_W-1:0]        best_idx,
  output logic                    done
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SUM_W = PIXEL + $clog2(NUM_PE);

  state_t           r_state;
  logic [ROW_W-1:0] r_row_cnt;
  logic [IDX_W-1:0] r_cand_cnt;
  logic             r_flush_cnt;
  logic [SAD_W-1:0] r_acc;
  logic             r_s2_last;
  logic [IDX_W-1:0] r_cmp_idx;

  logic             w_accept;
  logic             w_last_row;
  logic             w_last_cand;
  logic             w_s1_valid;
  logic [SUM_W-1:0] w_s1_sum;
  logic [1:0]       w_s1_tag;
  logic [SAD_W-1:0] w_acc_sum;

  assign w_accept    = (r_state == ACCUM) && abs_valid && !search_start;
  assign w_last_row  = (r_row_cnt == ROW_W'(ROWS - 1));
  assign w_last_cand = (r_cand_cnt == IDX_W'(NUM_CAND - 1));
  assign w_acc_sum   = r_acc + SAD_W'(w_s1_sum);

  // FSM: FLUSH lasts two cycles so IDLE/busy=0 lines up with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_cand_cnt  <= '0;
      r_flush_cnt <= 1'b0;
      busy        <= 1'b0;
    end else if (search_start) begin
      r_state     <= ACCUM;
      r_row_cnt   <= '0;
      r_cand_cnt  <= '0;
      r_flush_cnt <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_last_row) begin
              r_row_cnt  <= '0;
              r_cand_cnt <= r_cand_cnt + IDX_W'(1);
              if (w_last_cand) r_state <= FLUSH;
            end else begin
              r_row_cnt <= r_row_cnt + ROW_W'(1);
            end
          end
        end
        FLUSH: begin
          r_flush_cnt <= 1'b1;
          if (r_flush_cnt) begin
            r_state     <= IDLE;
            r_flush_cnt <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag bit 1: last row of a candidate; bit 0: last row of the last candidate.
  sad_row_adder #(
    .PIXEL (PIXEL),
    .NUM_PE(NUM_PE),
    .TAG_W (2),
    .SUM_W (SUM_W)
  ) u_row_adder (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (search_start),
    .i_valid(w_accept),
    .i_row  (abs_row),
    .i_tag  ({w_last_row, w_last_row & w_last_cand}),
    .o_valid(w_s1_valid),
    .o_sum  (w_s1_sum),
    .o_tag  (w_s1_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      cand_sad   <= '0;
      cand_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      cand_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      if (search_start) begin
        r_acc <= '0;
      end else if (w_s1_valid) begin
        if (w_s1_tag[1]) begin
          cand_sad   <= w_acc_sum;
          cand_valid <= 1'b1;
          r_s2_last  <= w_s1_tag[0];
          r_acc      <= '0;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad  <= '0;
      best_idx  <= '0;
      r_cmp_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (search_start) begin
        best_sad  <= '1;
        best_idx  <= '0;
        r_cmp_idx <= '0;
      end else if (cand_valid) begin
        r_cmp_idx <= r_cmp_idx + IDX_W'(1);
        done      <= r_s2_last;
        if (cand_sad < best_sad) begin
          best_sad <= cand_sad;
          best_idx <= r_cmp_idx;
        end
      end
    end
  end

endmodule
